aes_sb_mc_engine: RTL and testbench

//  Parametrised AES round datapath stage: SubBytes+MixColumns (encrypt) or the exact inverse

---
 rtl/aes_sb_mc_engine.sv | 174 +++++++++++++++++
 tb/tb_aes_sb_mc_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aes_sb_mc_engine.sv
// AES round datapath stage: SubBytes+MixColumns (forward) or InvMixColumns+InvSubBytes
// (inverse), with MixColumns bypass for the final round. Valid/ready on both sides.
// Columns are transformed COLS_PER_CYCLE at a time over NPASS cycles.
module aes_sb_mc_engine #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         mode_inv,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NPASS = 4 / COLS_PER_CYCLE;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("aes_sb_mc_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t       state_reg, state_next;
    logic [127:0] data_reg;
    logic         mode_reg;
    logic         last_reg;
    logic [1:0]   col_cnt_reg;
    logic [31:0]  res_reg [4];
    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];
    logic         accept;
    logic         last_pass;

    // GF(2^8) multiply, reduction polynomial 0x11b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Forward S-box: inverse followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map followed by the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    // One column through the selected transform; byte 0 is row 0 (MSBs)
    function automatic logic [31:0] col_xform(input logic [31:0] col, input logic inv,
                                              input logic last);
        logic [7:0] b [4];
        logic [7:0] m [4];
        logic [7:0] r [4];
        for (int i = 0; i < 4; i++) b[i] = col[31-8*i -: 8];
        if (!inv) begin
            for (int i = 0; i < 4; i++) m[i] = sbox(b[i]);
            if (last) begin
                for (int i = 0; i < 4; i++) r[i] = m[i];
            end else begin
                for (int i = 0; i < 4; i++)
                    r[i] = gf_mul(m[i], 8'h02) ^ gf_mul(m[(i+1)%4], 8'h03) ^ m[(i+2)%4] ^ m[(i+3)%4];
            end
        end else begin
            if (last) begin
                for (int i = 0; i < 4; i++) m[i] = b[i];
            end else begin
                for (int i = 0; i < 4; i++)
                    m[i] = gf_mul(b[i], 8'h0e) ^ gf_mul(b[(i+1)%4], 8'h0b)
                         ^ gf_mul(b[(i+2)%4], 8'h0d) ^ gf_mul(b[(i+3)%4], 8'h09);
            end
            for (int i = 0; i < 4; i++) r[i] = inv_sbox(m[i]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_pass = (col_cnt_reg == 2'(NPASS - 1));
    assign state_out = {res_reg[0], res_reg[1], res_reg[2], res_reg[3]};

    // Column lanes: lane gi handles column col_cnt*COLS_PER_CYCLE + gi of the captured state
    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign col_idx[gi] = 2'(int'(col_cnt_reg) * COLS_PER_CYCLE + gi);
            assign col_out[gi] = col_xform(data_reg[(3 - int'(col_idx[gi])) * 32 +: 32],
                                           mode_reg, last_reg);
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (last_pass) state_next = HOLD;
            HOLD:    if (out_ready) state_next = in_valid ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            IDLE: in_ready = rst;
            CALC: busy = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Capture on accept; in CALC write this pass's columns into the result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg    <= '0;
            mode_reg    <= 1'b0;
            last_reg    <= 1'b0;
            col_cnt_reg <= 2'd0;
            for (int i = 0; i < 4; i++) res_reg[i] <= '0;
        end else if (accept) begin
            data_reg    <= state_in;
            mode_reg    <= mode_inv;
            last_reg    <= last_round;
            col_cnt_reg <= 2'd0;
        end else if (state_reg == CALC) begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) res_reg[col_idx[j]] <= col_out[j];
            col_cnt_reg <= last_pass ? 2'd0 : col_cnt_reg + 2'd1;
        end
    end

endmodule

// File: tb/tb_aes_sb_mc_engine.sv
// Directed bench for aes_sb_mc_engine: a fully parallel instance and a column-serial one.
module tb_aes_sb_mc_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         in_valid4 = 1'b0, in_ready4, mode_inv4 = 1'b0, last_round4 = 1'b0;
    logic         out_valid4, out_ready4 = 1'b0, busy4;
    logic [127:0] state_in4 = '0, state_out4;

    logic         in_valid1 = 1'b0, in_ready1, mode_inv1 = 1'b0, last_round1 = 1'b0;
    logic         out_valid1, out_ready1 = 1'b0, busy1;
    logic [127:0] state_in1 = '0, state_out1;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] V_IN   = 128'h19f48d08a0c648be9af8e32be93de22a;
    localparam logic [127:0] V_MC   = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] V_SB   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ALL63  = {16{8'h63}};

    always #5 clk = ~clk;

    aes_sb_mc_engine #(.COLS_PER_CYCLE(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .state_in(state_in4), .mode_inv(mode_inv4), .last_round(last_round4),
        .out_valid(out_valid4), .out_ready(out_ready4), .state_out(state_out4), .busy(busy4)
    );

    aes_sb_mc_engine #(.COLS_PER_CYCLE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .state_in(state_in1), .mode_inv(mode_inv1), .last_round(last_round1),
        .out_valid(out_valid1), .out_ready(out_ready1), .state_out(state_out1), .busy(busy1)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One block through the parallel instance; inputs are scrambled after accept
    task automatic run4(input string tag, input logic [127:0] din, input logic inv,
                        input logic last, input logic [127:0] exp);
        @(negedge clk);
        check1({tag, "_in_ready_idle"}, in_ready4, 1'b1);
        state_in4 = din; mode_inv4 = inv; last_round4 = last; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b0; state_in4 = ~din; mode_inv4 = ~inv; last_round4 = ~last;
        check1({tag, "_calc_out_valid"}, out_valid4, 1'b0);
        check1({tag, "_calc_busy"}, busy4, 1'b1);
        check1({tag, "_calc_in_ready"}, in_ready4, 1'b0);
        @(negedge clk);
        check1({tag, "_out_valid"}, out_valid4, 1'b1);
        check128({tag, "_state_out"}, state_out4, exp);
        $display("txn %s cpc=4 in=%h inv=%b last=%b out=%h", tag, din, inv, last, state_out4);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check1({tag, "_idle_out_valid"}, out_valid4, 1'b0);
        check1({tag, "_idle_busy"}, busy4, 1'b0);
    endtask

    // One block through the column-serial instance: four CALC cycles expected
    task automatic run1(input string tag, input logic [127:0] din, input logic inv,
                        input logic last, input logic [127:0] exp);
        @(negedge clk);
        check1({tag, "_in_ready_idle"}, in_ready1, 1'b1);
        state_in1 = din; mode_inv1 = inv; last_round1 = last; in_valid1 = 1'b1; out_ready1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid1 = 1'b0; state_in1 = ~din; mode_inv1 = ~inv;
            check1($sformatf("%s_calc%0d_out_valid", tag, i), out_valid1, 1'b0);
            check1($sformatf("%s_calc%0d_in_ready", tag, i), in_ready1, 1'b0);
        end
        @(negedge clk);
        check1({tag, "_out_valid"}, out_valid1, 1'b1);
        check1({tag, "_hold_in_ready"}, in_ready1, 1'b0);
        check128({tag, "_state_out"}, state_out1, exp);
        $display("txn %s cpc=1 in=%h inv=%b last=%b out=%h", tag, din, inv, last, state_out1);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check1({tag, "_idle_out_valid"}, out_valid1, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check1("rst_out_valid4", out_valid4, 1'b0);
        check1("rst_busy4", busy4, 1'b0);
        check1("rst_in_ready4", in_ready4, 1'b0);
        check128("rst_state_out4", state_out4, 128'h0);
        check1("rst_out_valid1", out_valid1, 1'b0);
        check1("rst_in_ready1", in_ready1, 1'b0);
        check128("rst_state_out1", state_out1, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Parallel instance: full rounds and final rounds both directions
        run4("fwd", V_IN, 1'b0, 1'b0, V_MC);
        run4("inv", V_MC, 1'b1, 1'b0, V_IN);
        run4("fwd_last_zero", 128'h0, 1'b0, 1'b1, ALL63);
        run4("inv_last_63", ALL63, 1'b1, 1'b1, 128'h0);
        run4("fwd_last", V_IN, 1'b0, 1'b1, V_SB);
        run4("inv_last", V_SB, 1'b1, 1'b1, V_IN);

        // Backpressure, then back-to-back accept out of HOLD
        @(negedge clk);
        state_in4 = V_IN; mode_inv4 = 1'b0; last_round4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(negedge clk);
        state_in4 = V_MC; mode_inv4 = 1'b1; in_valid4 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check1($sformatf("bp%0d_out_valid", i), out_valid4, 1'b1);
            check1($sformatf("bp%0d_in_ready", i), in_ready4, 1'b0);
            check128($sformatf("bp%0d_state_out", i), state_out4, V_MC);
            @(negedge clk);
        end
        out_ready4 = 1'b1;
        #1;
        check1("b2b_in_ready", in_ready4, 1'b1);
        $display("txn bp_first cpc=4 out=%h", state_out4);
        @(negedge clk);
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        check1("b2b_calc_out_valid", out_valid4, 1'b0);
        check1("b2b_calc_busy", busy4, 1'b1);
        @(negedge clk);
        check1("b2b_out_valid", out_valid4, 1'b1);
        check128("b2b_state_out", state_out4, V_IN);
        $display("txn bp_second cpc=4 out=%h", state_out4);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check1("b2b_idle_out_valid", out_valid4, 1'b0);

        // Column-serial instance
        run1("s_fwd", V_IN, 1'b0, 1'b0, V_MC);
        run1("s_inv", V_MC, 1'b1, 1'b0, V_IN);

        // Reset two passes into a serial computation
        @(negedge clk);
        state_in1 = V_IN; mode_inv1 = 1'b0; last_round1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("midrst_out_valid", out_valid1, 1'b0);
        check1("midrst_busy", busy1, 1'b0);
        check1("midrst_in_ready", in_ready1, 1'b0);
        check128("midrst_state_out", state_out1, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1($sformatf("postrst%0d_out_valid", i), out_valid1, 1'b0);
        end
        out_ready1 = 1'b0;
        run1("s_after_rst", V_IN, 1'b0, 1'b0, V_MC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
